gpu_bus_dma: RTL

Bus-initiator DMA engine that drives the GPU's 32-bit host bus slave port (addr/data/sel/rd/we/ack) from the CPU side. It issues the transactions that the GPU SRAM arbiter answers, filling a framebuffer region with a constant word or copying a region word-by-word. It sits between the CPU register file and the GPU bus port, and offloads framebuffer clears and blits from the CPU.

---
 rtl/gpu_bus_dma.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/gpu_bus_dma.sv
// ============================================================================
// gpu_bus_dma : bus-initiator DMA that fills or copies framebuffer words
//               over the GPU host bus (addr/data/sel/rd/we/ack).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module gpu_bus_dma #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    input  logic        cfg_mode,
    input  logic [31:0] cfg_src,
    input  logic [31:0] cfg_dst,
    input  logic [19:0] cfg_count,
    input  logic [31:0] cfg_pattern,
    input  logic        cfg_abort,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [19:0] words_left,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    output logic [1:0]  bus_sel_o,
    output logic        bus_rd_o,
    output logic        bus_we_o,
    input  logic        bus_ack_i
);

    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        WR_REQ = 3'd2,
        GAP    = 3'd3,
        FIN    = 3'd4
    } state_e;

    state_e      state_q, state_d, next_q, next_d;
    logic        mode_q, mode_d, abort_q, abort_d;
    logic [31:0] src_q, src_d, dst_q, dst_d, pattern_q, pattern_d, hold_q, hold_d;
    logic [19:0] words_left_q, words_left_d;
    logic [7:0]  wait_q, wait_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, data_q, data_d;
    logic [1:0]  sel_q, sel_d;
    logic        rd_q, rd_d, we_q, we_d;
    logic        w_abort_any;

    assign w_abort_any = abort_q | cfg_abort;

    always_comb begin
        state_d      = state_q;
        next_d       = next_q;
        mode_d       = mode_q;
        abort_d      = abort_q;
        src_d        = src_q;
        dst_d        = dst_q;
        pattern_d    = pattern_q;
        hold_d       = hold_q;
        words_left_d = words_left_q;
        wait_d       = wait_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        addr_d       = addr_q;
        data_d       = data_q;
        sel_d        = sel_q;
        rd_d         = rd_q;
        we_d         = we_q;

        if (state_q != IDLE && cfg_abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    mode_d       = cfg_mode;
                    src_d        = cfg_src;
                    dst_d        = cfg_dst;
                    pattern_d    = cfg_pattern;
                    words_left_d = cfg_count;
                    err_d        = 1'b0;
                    abort_d      = 1'b0;
                    busy_d       = 1'b1;
                    wait_d       = 8'd0;
                    // Zero-length jobs spend one idle GAP cycle so done lands at start+2.
                    if (cfg_count == 20'd0) begin
                        state_d = GAP;
                        next_d  = FIN;
                    end else if (cfg_mode) begin
                        state_d = RD_REQ;
                        addr_d  = cfg_src;
                        rd_d    = 1'b1;
                        sel_d   = 2'b11;
                    end else begin
                        state_d = WR_REQ;
                        addr_d  = cfg_dst;
                        data_d  = cfg_pattern;
                        we_d    = 1'b1;
                        sel_d   = 2'b11;
                    end
                end
            end
            RD_REQ: begin
                if (bus_ack_i) begin
                    hold_d  = bus_data_i;
                    src_d   = src_q + 32'd4;
                    rd_d    = 1'b0;
                    sel_d   = 2'b00;
                    state_d = GAP;
                    next_d  = WR_REQ;
                end else if (wait_q == c_wait_last) begin
                    rd_d    = 1'b0;
                    sel_d   = 2'b00;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WR_REQ: begin
                if (bus_ack_i) begin
                    dst_d        = dst_q + 32'd4;
                    words_left_d = words_left_q - 20'd1;
                    we_d         = 1'b0;
                    sel_d        = 2'b00;
                    state_d      = GAP;
                    if (words_left_q == 20'd1 || w_abort_any) begin
                        next_d = FIN;
                    end else begin
                        next_d = mode_q ? RD_REQ : WR_REQ;
                    end
                end else if (wait_q == c_wait_last) begin
                    we_d    = 1'b0;
                    sel_d   = 2'b00;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            GAP: begin
                // An abort arriving in the gap after a write stops before the next word starts.
                if (next_q == FIN ||
                    (w_abort_any && next_q == (mode_q ? RD_REQ : WR_REQ))) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end else if (next_q == RD_REQ) begin
                    state_d = RD_REQ;
                    addr_d  = src_q;
                    rd_d    = 1'b1;
                    sel_d   = 2'b11;
                    wait_d  = 8'd0;
                end else begin
                    state_d = WR_REQ;
                    addr_d  = dst_q;
                    data_d  = mode_q ? hold_q : pattern_q;
                    we_d    = 1'b1;
                    sel_d   = 2'b11;
                    wait_d  = 8'd0;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            next_q       <= IDLE;
            mode_q       <= 1'b0;
            abort_q      <= 1'b0;
            src_q        <= 32'd0;
            dst_q        <= 32'd0;
            pattern_q    <= 32'd0;
            hold_q       <= 32'd0;
            words_left_q <= 20'd0;
            wait_q       <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= 32'd0;
            data_q       <= 32'd0;
            sel_q        <= 2'b00;
            rd_q         <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_q       <= next_d;
            mode_q       <= mode_d;
            abort_q      <= abort_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            pattern_q    <= pattern_d;
            hold_q       <= hold_d;
            words_left_q <= words_left_d;
            wait_q       <= wait_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            rd_q         <= rd_d;
            we_q         <= we_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_left = words_left_q;
    assign bus_addr_o = addr_q;
    assign bus_data_o = data_q;
    assign bus_sel_o  = sel_q;
    assign bus_rd_o   = rd_q;
    assign bus_we_o   = we_q;

endmodule

`default_nettype wire
